// File: rtl/wb_reg_file_pkg.sv
// Shared writeback definitions: wrCtrl encodings and register-file geometry.
// Also imported by the control unit and the memWr-stage logic.
package wb_reg_file_pkg;

   localparam int DATA_W    = 32;
   localparam int NUM_REGS  = 32;
   localparam int REG_IDX_W = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      WB_NONE = 2'b00,
      WB_ALU  = 2'b01,
      WB_MEM  = 2'b10,
      WB_LINK = 2'b11
   } wr_ctrl_e;

   function automatic logic writes_reg(input logic [1:0] ctrl);
      return ctrl != WB_NONE;
   endfunction

endpackage

// File: rtl/wb_reg_file_if.sv
// Writeback-stage bus: MEM/WB inputs, the two read ports and the forwarding outputs.
interface wb_reg_file_if #(
   parameter int DATA_W = wb_reg_file_pkg::DATA_W,
   parameter int IDX_W  = wb_reg_file_pkg::REG_IDX_W
);
   logic [DATA_W-1:0] aluResultWb;
   logic [DATA_W-1:0] memDataWb;
   logic [DATA_W-1:0] linkAddrWb;
   logic [IDX_W-1:0]  rWWb;
   logic [1:0]        wrCtrlWb;
   logic [IDX_W-1:0]  rA;
   logic [IDX_W-1:0]  rB;
   logic [DATA_W-1:0] busA;
   logic [DATA_W-1:0] busB;
   logic [DATA_W-1:0] wbData;
   logic              wbValid;

   modport master (
      output aluResultWb, memDataWb, linkAddrWb, rWWb, wrCtrlWb, rA, rB,
      input  busA, busB, wbData, wbValid
   );

   modport slave (
      input  aluResultWb, memDataWb, linkAddrWb, rWWb, wrCtrlWb, rA, rB,
      output busA, busB, wbData, wbValid
   );
endinterface

// File: rtl/wb_reg_file_reg_array.sv
// Raw register storage: one write port, two combinational read ports, r0 hard-wired to 0.
module wb_reg_file_reg_array #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr_a,
   input  logic [IDX_W-1:0]  raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);
   logic [DATA_W-1:0] rd_vec [NUM_REGS];

   // Storage needs an asynchronous clear, so it is built from flops rather than RAM.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign rd_vec[gi] = '0;
      end else begin : g_store
         logic [DATA_W-1:0] q_reg;

         always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
               q_reg <= '0;
            end else if (we && (waddr == IDX_W'(gi))) begin
               q_reg <= wdata;
            end
         end

         assign rd_vec[gi] = q_reg;
      end
   end

   assign rdata_a = rd_vec[raddr_a];
   assign rdata_b = rd_vec[raddr_b];
endmodule

// File: rtl/wb_reg_file.sv
// Writeback-stage register file: writeback mux, write-through bypass,
// commit strobe and an internal retire counter around the raw storage.
module wb_reg_file #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic           clk,
   input  logic           resetN,
   wb_reg_file_if.slave   bus
);
   import wb_reg_file_pkg::*;

   localparam int IDX_W = $clog2(NUM_REGS);

   logic [DATA_W-1:0] wb_data;
   logic              wb_valid;
   logic [DATA_W-1:0] raw_a;
   logic [DATA_W-1:0] raw_b;
   logic [31:0]       retire_cnt_reg;

   always_comb begin
      wb_data = '0;
      case (bus.wrCtrlWb)
         WB_ALU:  wb_data = bus.aluResultWb;
         WB_MEM:  wb_data = bus.memDataWb;
         WB_LINK: wb_data = bus.linkAddrWb;
         default: wb_data = '0;
      endcase
   end

   // Index 0 never commits, which also keeps r0 out of the bypass path.
   assign wb_valid = writes_reg(bus.wrCtrlWb) && (bus.rWWb != '0);

   wb_reg_file_reg_array #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) reg_array (
      .clk     (clk),
      .resetN  (resetN),
      .we      (wb_valid),
      .waddr   (bus.rWWb),
      .wdata   (wb_data),
      .raddr_a (bus.rA),
      .raddr_b (bus.rB),
      .rdata_a (raw_a),
      .rdata_b (raw_b)
   );

   assign bus.busA    = (wb_valid && (bus.rA == bus.rWWb)) ? wb_data : raw_a;
   assign bus.busB    = (wb_valid && (bus.rB == bus.rWWb)) ? wb_data : raw_b;
   assign bus.wbData  = wb_data;
   assign bus.wbValid = wb_valid;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         retire_cnt_reg <= '0;
      end else if (wb_valid) begin
         retire_cnt_reg <= retire_cnt_reg + 32'd1;
      end
   end

   wr_ctrl_known: assert property (@(posedge clk) disable iff (!resetN) !$isunknown(bus.wrCtrlWb));
endmodule

// File: tb/tb_wb_reg_file.sv
// Randomized and directed stimulus for wb_reg_file, checked every cycle against
// an array-based model of the architectural registers and retire count.
module tb_wb_reg_file;
   logic clk = 1'b0;
   logic resetN;

   always #5 clk = ~clk;

   wb_reg_file_if #(.DATA_W(32), .IDX_W(5)) bus();

   wb_reg_file #(.DATA_W(32), .NUM_REGS(32)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   logic [31:0] model_regs [32];
   logic [31:0] model_writes;
   logic [31:0] cnt_base;
   int          checks = 0;
   int          errors = 0;
   int          txn    = 0;

   function automatic logic [31:0] exp_wbdata();
      case (bus.wrCtrlWb)
         2'd1:    return bus.aluResultWb;
         2'd2:    return bus.memDataWb;
         2'd3:    return bus.linkAddrWb;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic exp_valid();
      return (bus.wrCtrlWb != 2'd0) && (bus.rWWb != 5'd0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] idx);
      if (exp_valid() && idx == bus.rWWb) return exp_wbdata();
      return model_regs[idx];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_writes = 32'd0;
      cnt_base     = 32'd0;
   endtask

   // Sample half a cycle away from the active edge and compare everything.
   task automatic half();
      @(negedge clk);
      chk("wbData",  bus.wbData, exp_wbdata());
      chk("wbValid", {31'd0, bus.wbValid}, {31'd0, exp_valid()});
      chk("busA",    bus.busA, exp_read(bus.rA));
      chk("busB",    bus.busB, exp_read(bus.rB));
      chk("retire_cnt", dut.retire_cnt_reg, cnt_base + model_writes);
      txn++;
      $display("txn %0d rstn=%0b ctrl=%0d rw=%0d rA=%0d rB=%0d wbData=%h busA=%h busB=%h cnt=%h",
               txn, resetN, bus.wrCtrlWb, bus.rWWb, bus.rA, bus.rB,
               bus.wbData, bus.busA, bus.busB, dut.retire_cnt_reg);
   endtask

   task automatic edge_clk();
      @(posedge clk);
      if (resetN && exp_valid()) begin
         model_regs[bus.rWWb] = exp_wbdata();
         model_writes         = model_writes + 32'd1;
      end
      #1;
   endtask

   task automatic step();
      half();
      edge_clk();
   endtask

   task automatic set_in(input logic [1:0] ctrl, input logic [4:0] rw, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] link,
                         input logic [4:0] ra, input logic [4:0] rb);
      bus.wrCtrlWb    = ctrl;
      bus.rWWb        = rw;
      bus.aluResultWb = alu;
      bus.memDataWb   = mem;
      bus.linkAddrWb  = link;
      bus.rA          = ra;
      bus.rB          = rb;
   endtask

   task automatic rand_in();
      logic [4:0] rw;
      logic [4:0] ra;
      logic [4:0] rb;
      rw = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? rw : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      set_in(2'($urandom_range(0, 3)), rw, $urandom, $urandom, $urandom, ra, rb);
   endtask

   task automatic read_all_in_reset(input string tag);
      for (int i = 0; i < 32; i++) begin
         set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
         half();
         chk({tag, "_busA"}, bus.busA, 32'd0);
         chk({tag, "_cnt"}, dut.retire_cnt_reg, 32'd0);
         edge_clk();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      resetN = 1'b0;
      model_clear();
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      @(posedge clk);
      #1;

      // Reset state, plus a write attempt that must bypass but not commit.
      read_all_in_reset("rst0");
      set_in(2'd1, 5'd6, 32'h0BAD_0BAD, 32'd0, 32'd0, 5'd6, 5'd1);
      half();
      chk("rst_bypass_busA", bus.busA, 32'h0BAD_0BAD);
      edge_clk();
      resetN = 1'b1;

      // ALU write becomes visible through storage one edge later.
      set_in(2'd1, 5'd5, 32'h1234_5678, 32'd0, 32'd0, 5'd6, 5'd0);
      step();
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd6);
      half();
      chk("alu_wr_busA", bus.busA, 32'h1234_5678);
      chk("rst_blocked_busB", bus.busB, 32'd0);
      edge_clk();

      // Same-cycle bypass on both ports.
      set_in(2'd2, 5'd7, 32'd0, 32'hDEAD_BEEF, 32'd0, 5'd7, 5'd7);
      half();
      chk("bypass_busA", bus.busA, 32'hDEAD_BEEF);
      chk("bypass_busB", bus.busB, 32'hDEAD_BEEF);
      edge_clk();

      // Writes to r0 are discarded.
      set_in(2'd3, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 5'd0, 5'd7);
      half();
      chk("r0_wbValid", {31'd0, bus.wbValid}, 32'd0);
      chk("r0_busA", bus.busA, 32'd0);
      chk("r0_busB", bus.busB, 32'hDEAD_BEEF);
      edge_clk();
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      half();
      chk("r0_busA_after", bus.busA, 32'd0);
      chk("r0_cnt", dut.retire_cnt_reg, 32'd2);
      edge_clk();

      // No-write control leaves r3 alone.
      set_in(2'd1, 5'd3, 32'h0000_3333, 32'd0, 32'd0, 5'd0, 5'd0);
      step();
      set_in(2'd0, 5'd3, 32'hAAAA_AAAA, 32'd0, 32'd0, 5'd3, 5'd0);
      half();
      chk("nowr_wbData", bus.wbData, 32'd0);
      chk("nowr_wbValid", {31'd0, bus.wbValid}, 32'd0);
      chk("nowr_busA", bus.busA, 32'h0000_3333);
      edge_clk();
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd3);
      half();
      chk("nowr_busA_after", bus.busA, 32'h0000_3333);
      edge_clk();

      // Back-to-back writes to one index.
      set_in(2'd1, 5'd9, 32'h0000_0011, 32'd0, 32'd0, 5'd9, 5'd9);
      half();
      chk("b2b_first_busA", bus.busA, 32'h0000_0011);
      edge_clk();
      set_in(2'd2, 5'd9, 32'd0, 32'h0000_0022, 32'd0, 5'd9, 5'd0);
      half();
      chk("b2b_second_busA", bus.busA, 32'h0000_0022);
      edge_clk();
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd9);
      half();
      chk("b2b_last_wins", bus.busB, 32'h0000_0022);
      chk("b2b_cnt", dut.retire_cnt_reg, 32'd5);
      edge_clk();

      repeat (300) begin
         rand_in();
         step();
      end

      // Mid-run reset: clears immediately, blocks writes, bypass still live.
      resetN = 1'b0;
      model_clear();
      repeat (3) begin
         rand_in();
         step();
      end
      read_all_in_reset("rst1");
      set_in(2'd1, 5'd4, 32'h0BAD_BAD0, 32'd0, 32'd0, 5'd4, 5'd4);
      step();
      resetN = 1'b1;
      set_in(2'd1, 5'd4, 32'hCAFE_F00D, 32'd0, 32'd0, 5'd0, 5'd4);
      step();
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd4, 5'd0);
      half();
      chk("rel_first_write", bus.busA, 32'hCAFE_F00D);
      chk("rel_cnt", dut.retire_cnt_reg, 32'd1);
      edge_clk();

      // Counter wrap.
      cnt_base = 32'hFFFF_FFFF - model_writes;
      force dut.retire_cnt_reg = 32'hFFFF_FFFF;
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd2);
      half();
      release dut.retire_cnt_reg;
      #1;
      set_in(2'd1, 5'd12, 32'h1357_9BDF, 32'd0, 32'd0, 5'd12, 5'd4);
      edge_clk();
      set_in(2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd12, 5'd4);
      half();
      chk("wrap_cnt", dut.retire_cnt_reg, 32'd0);
      chk("wrap_busA", bus.busA, 32'h1357_9BDF);
      edge_clk();

      repeat (200) begin
         rand_in();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
